// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Streams strobed bytes into the program RAM write port from a
//               programmable base address, with terminator/full/overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    USE_END_BYTE = 1,
    parameter logic [DATA_WIDTH-1:0] END_BYTE     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  newData,
    output logic                  write_rq,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_nd_q;

    logic w_edge;
    logic w_term;
    logic w_last;

    assign w_edge = newData & ~r_nd_q;
    // addr/data still hold the in-flight write while write_rq is high
    assign w_term = (USE_END_BYTE != 0) && (data == END_BYTE);
    assign w_last = (addr == c_ADDR_MAX);

    assign busy = (r_state == S_LOAD);
    assign done = (r_state == S_DONE);
    assign full = (r_state == S_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_nd_q   <= 1'b0;
            write_rq <= 1'b0;
            addr     <= '0;
            data     <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            r_nd_q   <= newData;
            write_rq <= 1'b0;
            if (start) begin
                // A coincident edge is deliberately dropped here
                r_state  <= S_LOAD;
                r_ptr    <= base_addr;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (write_rq) begin
                            count <= count + 1'b1;
                            if (!w_last) begin
                                r_ptr <= r_ptr + 1'b1;
                            end
                            if (w_term) begin
                                r_state <= S_DONE;
                            end else if (w_last) begin
                                r_state <= S_FULL;
                            end
                        end else if (w_edge) begin
                            write_rq <= 1'b1;
                            addr     <= r_ptr;
                            data     <= dataIn;
                        end
                    end
                    S_FULL: begin
                        if (w_edge) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  newData;
    logic                  write_rq;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
    logic                  full;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned wr_addr_q[$];
    int unsigned wr_data_q[$];

    program_loader #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .USE_END_BYTE(1),
        .END_BYTE    (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .dataIn   (dataIn),
        .newData  (newData),
        .write_rq (write_rq),
        .addr     (addr),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write, sampled mid-cycle
    always @(negedge clk) begin
        if (write_rq) begin
            wr_addr_q.push_back(int'(addr));
            wr_data_q.push_back(int'(data));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int unsigned b);
        base_addr = ADDR_WIDTH'(b);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
    endtask

    task automatic send_byte(input int unsigned v, input int hold);
        dataIn  = DATA_WIDTH'(v);
        newData = 1'b1;
        tick(hold);
        newData = 1'b0;
        tick(3);
    endtask

    task automatic check_writes(input string name, input int unsigned exp_a[$], input int unsigned exp_d[$]);
        check({name, "_nwrites"}, wr_addr_q.size(), exp_a.size());
        foreach (exp_a[i]) begin
            if (i < wr_addr_q.size()) begin
                check({name, "_addr"}, wr_addr_q[i], exp_a[i]);
                check({name, "_data"}, wr_data_q[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        check("reset_outputs", {write_rq, addr, data, busy, done, full, overflow, count}, 0);
        reset = 1'b1;
        tick(2);
        check("idle_busy", busy, 0);
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start(0);
        check("t1_busy_after_start", busy, 1);
        send_byte(7, 5);
        send_byte(8, 5);
        send_byte(18, 5);
        check_writes("t1", '{0, 1, 2}, '{7, 8, 18});
        check("t1_count", count, 3);
        check("t1_busy", busy, 1);
        check("t1_addr_hold", addr, 2);
        check("t1_data_hold", data, 18);
    endtask

    task automatic test_terminator();
        clear_log();
        pulse_start(0);
        send_byte(5, 2);
        send_byte(8'h00, 2);
        check_writes("t2", '{0, 1}, '{5, 0});
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_count", count, 2);
        clear_log();
        send_byte(9, 2);
        check("t2_no_write_after_done", wr_addr_q.size(), 0);
    endtask

    task automatic test_full_overflow();
        clear_log();
        pulse_start(62);
        check("t3_done_cleared", done, 0);
        send_byte(1, 2);
        send_byte(2, 2);
        check_writes("t3", '{62, 63}, '{1, 2});
        check("t3_full", full, 1);
        check("t3_busy", busy, 0);
        check("t3_ovf_before", overflow, 0);
        clear_log();
        send_byte(3, 2);
        check("t3_no_write", wr_addr_q.size(), 0);
        check("t3_overflow", overflow, 1);
        check("t3_count", count, 2);
        check("t3_still_full", full, 1);
    endtask

    task automatic test_start_collision();
        clear_log();
        pulse_start(0);
        check("t4_ovf_cleared", overflow, 0);
        check("t4_full_cleared", full, 0);
        send_byte(3, 2);
        base_addr = 6'd20;
        start     = 1'b1;
        dataIn    = 8'h44;
        newData   = 1'b1;
        tick();
        start     = 1'b0;
        tick(2);
        newData   = 1'b0;
        tick(3);
        check_writes("t4", '{0}, '{3});
        check("t4_count_zero", count, 0);
        check("t4_busy", busy, 1);
        send_byte(8'h55, 2);
        check("t4_ptr_base_addr", wr_addr_q.size() > 1 ? wr_addr_q[1] : 999, 20);
        check("t4_count_one", count, 1);
    endtask

    task automatic test_reset_midwrite();
        pulse_start(0);
        dataIn  = 8'h66;
        newData = 1'b1;
        tick();
        check("t5_write_rq_high", write_rq, 1);
        reset = 1'b0;
        #1;
        check("t5_write_rq_async_drop", write_rq, 0);
        newData = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("t5_outputs_zero", {write_rq, addr, data, busy, done, full, overflow, count}, 0);
    endtask

    task automatic test_held_newdata();
        clear_log();
        dataIn  = 8'h77;
        newData = 1'b1;
        tick(2);
        pulse_start(5);
        tick(3);
        check("t6_no_write_held", wr_addr_q.size(), 0);
        newData = 1'b0;
        tick(2);
        send_byte(8'h78, 2);
        check_writes("t6", '{5}, '{8'h78});
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        dataIn    = '0;
        newData   = 1'b0;
        test_reset();
        test_basic_load();
        test_terminator();
        test_full_overflow();
        test_start_collision();
        test_reset_midwrite();
        test_held_newdata();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
